// File: rtl/layernorm_seq_pkg.sv
// rtl/layernorm_seq_pkg.sv - sequencer state encoding and parameter-memory timing shared by layernorm_seq
package transformer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } ln_seq_state_e;

    localparam int LN_PM_RD_LAT = 1;

endpackage

// File: rtl/layernorm_seq_cfg_burst.sv
// rtl/layernorm_seq_cfg_burst.sv - gamma/beta burst: parameter-memory read counter and one-cycle read-to-cfg-write stage
module ln_cfg_burst #(
    parameter int DIM    = 64,
    parameter int DATA_W = 16,
    parameter int AW     = 9,
    localparam int CW    = $clog2(2 * DIM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_go,
    input  logic [AW-1:0]     i_base,
    input  logic [DATA_W-1:0] i_pm_rdata,
    output logic              o_pm_req,
    output logic [AW-1:0]     o_pm_addr,
    output logic              o_cfg_we,
    output logic [CW-1:0]     o_cfg_addr,
    output logic [DATA_W-1:0] o_cfg_wdata,
    output logic              o_last
);

    localparam logic [CW-1:0] K_LAST = CW'(2 * DIM - 1);

    logic          r_req;
    logic [CW-1:0] r_k;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [CW-1:0] r_waddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_k     <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
        end else begin
            // Write stage trails the read strobe by the memory read latency
            r_we    <= r_req;
            r_waddr <= r_k;
            if (i_go) begin
                r_req  <= 1'b1;
                r_k    <= '0;
                r_addr <= i_base;
            end else if (r_req) begin
                if (r_k == K_LAST) begin
                    r_req <= 1'b0;
                end else begin
                    r_k    <= r_k + CW'(1);
                    r_addr <= r_addr + AW'(1);
                end
            end
        end
    end

    assign o_pm_req    = r_req;
    assign o_pm_addr   = r_addr;
    assign o_cfg_we    = r_we;
    assign o_cfg_addr  = r_waddr;
    assign o_cfg_wdata = i_pm_rdata;
    assign o_last      = r_we && (r_waddr == K_LAST);

endmodule

// File: rtl/layernorm_seq.sv
// rtl/layernorm_seq.sv - layernorm sequencer: gamma/beta burst load then token gating; LN_SKIP_RELOAD_EN skips reloading the resident layer
module layernorm_seq
    import transformer_pkg::*;
#(
    parameter int DIM        = 64,
    parameter int DATA_W     = 16,
    parameter int NUM_LAYERS = 4,
    parameter int TOK_W      = 16,
    localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int AW        = $clog2(NUM_LAYERS * 2 * DIM),
    localparam int CW        = $clog2(2 * DIM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LW-1:0]     layer_id,
    input  logic [TOK_W-1:0]  num_tokens,
    output logic              busy,
    output logic              done,
    output logic [TOK_W-1:0]  tok_left,
    output logic              pm_req,
    output logic [AW-1:0]     pm_addr,
    input  logic [DATA_W-1:0] pm_rdata,
    output logic              ln_cfg_we,
    output logic [CW-1:0]     ln_cfg_addr,
    output logic [DATA_W-1:0] ln_cfg_wdata,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ln_valid_in,
    input  logic              ln_valid_out,
    output logic              m_valid,
    input  logic              m_ready
);

    ln_seq_state_e  r_state;
    ln_seq_state_e  w_state_nxt;
    logic [TOK_W-1:0] r_tok_left;
    logic [TOK_W-1:0] r_num_tok;
    logic           w_accept;
    logic           w_skip_hit;
    logic           w_go;
    logic           w_last;
    logic           w_run;
    logic           w_fire;
    logic [AW-1:0]  w_base;

    assign w_accept = (r_state == IDLE) && start;
    assign w_base   = AW'(layer_id) * AW'(2 * DIM);

`ifdef LN_SKIP_RELOAD_EN
    logic          r_loaded;
    logic [LW-1:0] r_last_layer;

    assign w_skip_hit = r_loaded && (layer_id == r_last_layer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loaded     <= 1'b0;
            r_last_layer <= '0;
        end else if (w_go) begin
            r_loaded     <= 1'b0;
            r_last_layer <= layer_id;
        end else if (r_state == LOAD && w_last) begin
            r_loaded <= 1'b1;
        end
    end
`else
    assign w_skip_hit = 1'b0;
`endif

    assign w_go = w_accept && !w_skip_hit;

    ln_cfg_burst #(
        .DIM    (DIM),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_burst (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_go        (w_go),
        .i_base      (w_base),
        .i_pm_rdata  (pm_rdata),
        .o_pm_req    (pm_req),
        .o_pm_addr   (pm_addr),
        .o_cfg_we    (ln_cfg_we),
        .o_cfg_addr  (ln_cfg_addr),
        .o_cfg_wdata (ln_cfg_wdata),
        .o_last      (w_last)
    );

    // Tokens only move in RUN so gamma/beta never change under a live vector
    assign w_run       = (r_state == RUN);
    assign s_ready     = m_ready & w_run;
    assign ln_valid_in = s_valid & w_run;
    assign m_valid     = ln_valid_out & w_run;
    assign w_fire      = s_valid & s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_skip_hit) begin
                        w_state_nxt = (num_tokens == '0) ? DONE : RUN;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (w_last) begin
                    w_state_nxt = (r_num_tok == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_fire && r_tok_left == TOK_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tok_left <= '0;
            r_num_tok  <= '0;
        end else begin
            if (w_accept) begin
                r_num_tok <= num_tokens;
                if (w_skip_hit) begin
                    r_tok_left <= num_tokens;
                end
            end else if (r_state == LOAD && w_last) begin
                r_tok_left <= r_num_tok;
            end else if (w_run && w_fire) begin
                r_tok_left <= r_tok_left - TOK_W'(1);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && w_accept) begin
            assert (32'(layer_id) < NUM_LAYERS);
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign tok_left = r_tok_left;

endmodule

// File: tb/tb_layernorm_seq.sv
// tb/tb_layernorm_seq.sv - randomized self-checking bench for layernorm_seq against a cycle-phase reference model
module tb_layernorm_seq;

    localparam int DIM        = 4;
    localparam int DATA_W     = 16;
    localparam int NUM_LAYERS = 4;
    localparam int TOK_W      = 16;
    localparam int LW         = 2;
    localparam int AW         = 5;
    localparam int CW         = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LW-1:0]     layer_id = '0;
    logic [TOK_W-1:0]  num_tokens = '0;
    logic              busy;
    logic              done;
    logic [TOK_W-1:0]  tok_left;
    logic              pm_req;
    logic [AW-1:0]     pm_addr;
    logic [DATA_W-1:0] pm_rdata = '0;
    logic              ln_cfg_we;
    logic [CW-1:0]     ln_cfg_addr;
    logic [DATA_W-1:0] ln_cfg_wdata;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              ln_valid_in;
    logic              ln_valid_out;
    logic              m_valid;
    logic              m_ready = 1'b0;

    logic [DATA_W-1:0] mem [NUM_LAYERS*2*DIM];
    int errors = 0;
    int checks = 0;
    bit tb_loaded = 1'b0;
    int tb_last = 0;

    layernorm_seq #(
        .DIM        (DIM),
        .DATA_W     (DATA_W),
        .NUM_LAYERS (NUM_LAYERS),
        .TOK_W      (TOK_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .layer_id     (layer_id),
        .num_tokens   (num_tokens),
        .busy         (busy),
        .done         (done),
        .tok_left     (tok_left),
        .pm_req       (pm_req),
        .pm_addr      (pm_addr),
        .pm_rdata     (pm_rdata),
        .ln_cfg_we    (ln_cfg_we),
        .ln_cfg_addr  (ln_cfg_addr),
        .ln_cfg_wdata (ln_cfg_wdata),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ln_valid_in  (ln_valid_in),
        .ln_valid_out (ln_valid_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    always #5 clk = ~clk;

    // Zero-latency layernorm datapath and one-cycle parameter memory
    assign ln_valid_out = ln_valid_in;
    always @(posedge clk) if (pm_req) pm_rdata <= mem[pm_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input int layer, input int ntok, input bit toggle, input bit stray);
        bit skip;
        bit fin;
        bit in_run;
        bit exp_done;
        bit exp_req;
        bit exp_we;
        int load_len;
        int xfers;
        int r;
        int base;
        skip = 1'b0;
`ifdef LN_SKIP_RELOAD_EN
        skip = tb_loaded && (layer == tb_last);
`endif
        load_len = skip ? 0 : 2 * DIM + 1;
        base     = layer * 2 * DIM;
        xfers    = 0;
        fin      = 1'b0;
        r        = 0;
        @(negedge clk);
        start = 1'b1; layer_id = layer[LW-1:0]; num_tokens = ntok[TOK_W-1:0];
        s_valid = 1'b0; m_ready = 1'b0;
        while (!fin) begin
            @(negedge clk);
            in_run   = (r >= load_len) && (xfers < ntok);
            exp_done = (r >= load_len) && (xfers == ntok);
            exp_req  = !skip && (r < 2 * DIM);
            exp_we   = !skip && (r >= 1) && (r <= 2 * DIM);
            start      = stray ? 1'($urandom_range(1, 0)) : 1'b0;
            layer_id   = LW'($urandom);
            num_tokens = TOK_W'($urandom);
            if (toggle) begin
                s_valid = 1'b1;
                m_ready = r[0];
            end else begin
                s_valid = 1'($urandom);
                m_ready = 1'($urandom);
            end
            #1;
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), 32'(exp_done));
            chk("pm_req", 32'(pm_req), 32'(exp_req));
            if (exp_req) chk("pm_addr", 32'(pm_addr), 32'(base + r));
            chk("cfg_we", 32'(ln_cfg_we), 32'(exp_we));
            if (exp_we) begin
                chk("cfg_addr", 32'(ln_cfg_addr), 32'(r - 1));
                chk("cfg_wdata", 32'(ln_cfg_wdata), 32'(mem[base + r - 1]));
            end
            chk("s_ready", 32'(s_ready), 32'(m_ready & in_run));
            chk("ln_valid_in", 32'(ln_valid_in), 32'(s_valid & in_run));
            chk("m_valid", 32'(m_valid), 32'(s_valid & in_run));
            if (in_run) chk("tok_left", 32'(tok_left), 32'(ntok - xfers));
            if (in_run && s_valid && m_ready) xfers++;
            if (exp_done) fin = 1'b1;
            r++;
            if (r > 300) begin
                chk("cmd_timeout", 32'd0, 32'd1);
                fin = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("xfer_count", 32'(xfers), 32'(ntok));
        if (!skip) begin
            tb_loaded = 1'b1;
            tb_last   = layer;
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_LAYERS * 2 * DIM; i++) mem[i] = DATA_W'($urandom);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pm_req", 32'(pm_req), 32'd0);
        chk("rst_cfg_we", 32'(ln_cfg_we), 32'd0);
        chk("rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("rst_cfg_addr", 32'(ln_cfg_addr), 32'd0);
        chk("rst_tok_left", 32'(tok_left), 32'd0);
        rst_n = 1'b1;

        do_cmd(2, 3, 1'b1, 1'b0);
        do_cmd(1, 0, 1'b0, 1'b0);
        do_cmd(3, 5, 1'b0, 1'b1);

        @(negedge clk);
        start = 1'b1; layer_id = 2'd1; num_tokens = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_pm_addr_w3", 32'(pm_addr), 32'd11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pm_req", 32'(pm_req), 32'd0);
        chk("mid_rst_cfg_we", 32'(ln_cfg_we), 32'd0);
        chk("mid_rst_tok_left", 32'(tok_left), 32'd0);
        tb_loaded = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post_rst_cfg_we", 32'(ln_cfg_we), 32'd0);
            chk("post_rst_pm_req", 32'(pm_req), 32'd0);
        end

        do_cmd(0, 2, 1'b0, 1'b0);
        do_cmd(0, 4, 1'b1, 1'b0);
        do_cmd(0, 0, 1'b0, 1'b1);
        do_cmd(2, 1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_cmd(int'($urandom_range(NUM_LAYERS - 1, 0)), int'($urandom_range(4, 0)), 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
